mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 145 ++++++++++++++
 tb/tb_mult_div_unit.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative 32-cycle multiply/divide unit with HI/LO registers.
// Shift-add multiply and restoring divide share one 64-bit accumulator.
module mult_div_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic        cancel,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic        sign_a_q, sign_a_d;
    logic        sign_b_q, sign_b_d;
    logic        div_zero_q, div_zero_d;
    logic [31:0] opnd_q, opnd_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        in_sign_a, in_sign_b;
    logic [31:0] mag_a, mag_b;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_shift;
    logic [31:0] div_diff;
    logic        div_ge;
    logic [63:0] div_next;
    logic [63:0] step;
    logic [63:0] prod;
    logic [31:0] quot;
    logic [31:0] rem;

    // Operand magnitudes; only the signed ops (op[0]=1) look at the sign bits.
    always_comb begin
        in_sign_a = op[0] & srcA[31];
        in_sign_b = op[0] & srcB[31];
        mag_a     = in_sign_a ? -srcA : srcA;
        mag_b     = in_sign_b ? -srcB : srcB;
    end

    // One iteration. Multiply keeps the multiplier in acc[31:0]; divide keeps
    // the partial remainder in acc[63:32] and shifts quotient bits into acc[31:0].
    always_comb begin
        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
        mul_next  = {mul_sum, acc_q[31:1]};
        div_shift = {acc_q[63:32], acc_q[31]};
        div_diff  = div_shift[31:0] - opnd_q;
        div_ge    = div_shift >= {1'b0, opnd_q};
        div_next  = {(div_ge ? div_diff : div_shift[31:0]), acc_q[30:0], div_ge};
        step      = op_q[1] ? div_next : mul_next;
        prod      = (sign_a_q ^ sign_b_q) ? -step : step;
        // A zero divisor leaves the dividend magnitude in the remainder; the
        // sign fix below restores srcA exactly, and the quotient is forced.
        quot      = div_zero_q ? 32'hFFFF_FFFF :
                    ((sign_a_q ^ sign_b_q) ? -step[31:0] : step[31:0]);
        rem       = sign_a_q ? -step[63:32] : step[63:32];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        div_zero_d = div_zero_q;
        opnd_d     = opnd_q;
        acc_d      = acc_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        case (state_q)
            IDLE: begin
                if (start && !cancel) begin
                    state_d    = RUN;
                    cnt_d      = 5'd31;
                    op_d       = op;
                    sign_a_d   = in_sign_a;
                    sign_b_d   = in_sign_b;
                    div_zero_d = (srcB == 32'd0);
                    opnd_d     = op[1] ? mag_b : mag_a;
                    acc_d      = {32'd0, (op[1] ? mag_a : mag_b)};
                end else begin
                    if (mthi) hi_d = wdata;
                    if (mtlo) lo_d = wdata;
                end
            end
            RUN: begin
                if (cancel) begin
                    state_d = IDLE;
                end else begin
                    acc_d = step;
                    cnt_d = cnt_q - 5'd1;
                    if (cnt_q == 5'd0) begin
                        state_d = IDLE;
                        hi_d    = op_q[1] ? rem  : prod[63:32];
                        lo_d    = op_q[1] ? quot : prod[31:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 5'd0;
            op_q       <= 2'd0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            div_zero_q <= 1'b0;
            opnd_q     <= 32'd0;
            acc_q      <= 64'd0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            sign_a_q   <= sign_a_d;
            sign_b_q   <= sign_b_d;
            div_zero_q <= div_zero_d;
            opnd_q     <= opnd_d;
            acc_q      <= acc_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy = (state_q == RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: expected {hi,lo} results are queued
// at issue time and compared when busy drops.
module tb_mult_div_unit;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        cancel;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    logic [63:0] exp_q[$];
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          n_checks;
    int          n_fail;

    mult_div_unit dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .op    (op),
        .srcA  (srcA),
        .srcB  (srcB),
        .cancel(cancel),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .wdata (wdata),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: returns {hi, lo}.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      p;
        int          sa, sb, q, r;
        logic [31:0] qv, rv;
        case (o)
            2'b00: model = {32'd0, a} * {32'd0, b};
            2'b01: begin
                p = longint'($signed(a)) * longint'($signed(b));
                model = p;
            end
            2'b10: begin
                if (b == 32'd0) model = {a, 32'hFFFF_FFFF};
                else            model = {a % b, a / b};
            end
            default: begin
                if (b == 32'd0) model = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    model = {32'd0, 32'h8000_0000};
                else begin
                    sa = a; sb = b;
                    q = sa / sb; r = sa % sb;
                    qv = q; rv = r;
                    model = {rv, qv};
                end
            end
        endcase
    endfunction

    // driver tasks: all are entered and left #1 after a rising edge
    task automatic cycles(input int k);
        repeat (k) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op    = o;
        srcA  = a;
        srcB  = b;
        start = 1'b1;
        exp_q.push_back(model(o, a, b));
        cycles(1);
        start = 1'b0;
    endtask

    task automatic write_hl(input logic h, input logic l, input logic [31:0] d);
        mthi  = h;
        mtlo  = l;
        wdata = d;
        cycles(1);
        mthi  = 1'b0;
        mtlo  = 1'b0;
        if (h) exp_hi = d;
        if (l) exp_lo = d;
    endtask

    // scoreboard: count busy cycles, then compare against the oldest entry
    task automatic wait_done(input string tag, input int lat);
        int          n;
        logic [63:0] e;
        n = 0;
        while (busy && n < 40) begin
            cycles(1);
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'(lat));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, " hi"}, {32'd0, hi}, {32'd0, e[63:32]});
            check({tag, " lo"}, {32'd0, lo}, {32'd0, e[31:0]});
            exp_hi = e[63:32];
            exp_lo = e[31:0];
        end
    endtask

    task automatic check_hold(input string tag);
        check({tag, " hi"}, {32'd0, hi}, {32'd0, exp_hi});
        check({tag, " lo"}, {32'd0, lo}, {32'd0, exp_lo});
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        start    = 1'b0;
        op       = 2'b00;
        srcA     = 32'd0;
        srcB     = 32'd0;
        cancel   = 1'b0;
        mthi     = 1'b0;
        mtlo     = 1'b0;
        wdata    = 32'd0;
        exp_hi   = 32'd0;
        exp_lo   = 32'd0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check("reset busy", {63'd0, busy}, 64'd0);
        check_hold("reset");

        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu max", 32);
        issue(2'b01, 32'hFFFF_FFFD, 32'd7);
        wait_done("mult -3x7", 32);
        issue(2'b11, 32'hFFFF_FFF9, 32'd2);
        wait_done("div -7/2", 32);
        issue(2'b10, 32'd100, 32'd0);
        wait_done("divu by 0", 32);
        issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div ovf", 32);
        issue(2'b11, 32'hFFFF_FFF9, 32'd0);
        wait_done("div neg by 0", 32);

        write_hl(1'b1, 1'b0, 32'h1234_5678);
        check_hold("mthi");
        write_hl(1'b1, 1'b1, 32'hA5A5_0F0F);
        check_hold("mthi+mtlo");

        // cancel / cancel+start in IDLE are no-ops
        cancel = 1'b1;
        cycles(1);
        check("cancel idle busy", {63'd0, busy}, 64'd0);
        start = 1'b1;
        op    = 2'b00;
        srcA  = 32'd3;
        srcB  = 32'd5;
        cycles(1);
        start  = 1'b0;
        cancel = 1'b0;
        check("cancel+start busy", {63'd0, busy}, 64'd0);
        check_hold("cancel idle");

        // mtlo during RUN is ignored
        issue(2'b01, 32'd1000, 32'hFFFF_FFFE);
        cycles(3);
        write_hl(1'b0, 1'b1, 32'hDEAD_BEEF);
        exp_lo = 32'hA5A5_0F0F;
        check_hold("mtlo in run");
        wait_done("mult after mtlo", 28);

        // start and mtlo on the same edge: only the operation lands
        mtlo  = 1'b1;
        wdata = 32'hCAFE_F00D;
        issue(2'b10, 32'd77, 32'd5);
        mtlo = 1'b0;
        check("start+mtlo lo", {32'd0, lo}, {32'd0, exp_lo});
        wait_done("start+mtlo", 32);

        // cancel at cycle 10 of DIVU 10/3
        issue(2'b10, 32'd10, 32'd3);
        cycles(8);
        cancel = 1'b1;
        cycles(1);
        cancel = 1'b0;
        void'(exp_q.pop_back());
        check("cancel busy", {63'd0, busy}, 64'd0);
        check_hold("cancel");
        issue(2'b10, 32'd10, 32'd3);
        wait_done("divu after cancel", 32);

        // stray start in RUN does not disturb the operation
        issue(2'b01, 32'h0001_2345, 32'hFFFF_0001);
        cycles(4);
        start = 1'b1;
        op    = 2'b10;
        srcA  = 32'd9;
        srcB  = 32'd4;
        cycles(1);
        start = 1'b0;
        wait_done("start in run", 27);

        // reset at cycle 15 of a MULT, then start on the first edge after
        issue(2'b01, 32'h7FFF_FFFF, 32'h8000_0001);
        cycles(13);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        void'(exp_q.pop_back());
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        check("mid reset busy", {63'd0, busy}, 64'd0);
        check_hold("mid reset");
        issue(2'b11, 32'd100, 32'hFFFF_FFF9);
        wait_done("after reset", 32);

        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'd1;
                3:       rb = 32'($urandom_range(2, 300));
                default: rb = $urandom;
            endcase
            issue(ro, ra, rb);
            wait_done($sformatf("rand%0d op%0d", i, ro), 32);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
